// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared state encoding, error codes and opcodes for calc_sequencer.
// Revision : 1.0
// ============================================================================
package calc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HAVE_A  = 3'd1,
        S_HAVE_B  = 3'd2,
        S_HAVE_AB = 3'd3,
        S_EXEC    = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL_OP = 2'b01;
    localparam logic [1:0] ERR_ALU        = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Operand-collection state from which operands are currently held.
    function automatic state_t haveState(input logic hasA, input logic hasB);
        case ({hasA, hasB})
            2'b10:   haveState = S_HAVE_A;
            2'b01:   haveState = S_HAVE_B;
            2'b11:   haveState = S_HAVE_AB;
            default: haveState = S_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pulse.sv
`default_nettype none
// ============================================================================
// Module   : edge_pulse
// Brief    : Rising-edge detector; history resets to 1 so a held level is quiet.
// Revision : 1.0
// ============================================================================
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= i_level;
        end
    end

    assign o_rise = i_level & ~r_hist & ~rst;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Brief    : Button-driven operand load / ALU op sequencer with watchdog.
// Revision : 1.0
// ============================================================================
module calc_sequencer #(
    parameter int OP_W    = 2,
    parameter int NUM_OPS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnLoadA,
    input  logic               btnLoadB,
    input  logic               btnExec,
    input  logic               btnClear,
    input  logic [OP_W-1:0]    op,
    input  logic               aluDone,
    input  logic               aluErr,
    output logic               loadA,
    output logic               loadB,
    output logic [NUM_OPS-1:0] opSel,
    output logic               aluStart,
    output logic               busy,
    output logic               resultValid,
    output logic [1:0]         errCode
);
    import calc_pkg::*;

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] c_wdLast = WD_W'(TIMEOUT - 1);

    logic w_edgeA, w_edgeB, w_edgeExec, w_edgeClr;

    edge_pulse u_edgeA    (.clk(clk), .rst(rst), .i_level(btnLoadA), .o_rise(w_edgeA));
    edge_pulse u_edgeB    (.clk(clk), .rst(rst), .i_level(btnLoadB), .o_rise(w_edgeB));
    edge_pulse u_edgeExec (.clk(clk), .rst(rst), .i_level(btnExec),  .o_rise(w_edgeExec));
    edge_pulse u_edgeClr  (.clk(clk), .rst(rst), .i_level(btnClear), .o_rise(w_edgeClr));

    state_t             r_state, w_nextState;
    logic [WD_W-1:0]    r_wd, w_wd;
    logic [NUM_OPS-1:0] r_opSel, w_opSel;
    logic [1:0]         r_err, w_err;
    logic               r_loadA, r_loadB, r_start, r_busy, r_resultValid;
    logic               w_loadA, w_loadB, w_start;
    logic               w_hasA, w_hasB, w_legal;

    always_comb begin
        w_nextState = r_state;
        w_wd        = r_wd;
        w_opSel     = r_opSel;
        w_err       = r_err;
        w_loadA     = 1'b0;
        w_loadB     = 1'b0;
        w_start     = 1'b0;
        w_hasA      = (r_state == S_HAVE_A) || (r_state == S_HAVE_AB);
        w_hasB      = (r_state == S_HAVE_B) || (r_state == S_HAVE_AB);
        w_legal     = (32'(op) < NUM_OPS);

        if (w_edgeClr) begin
            w_nextState = S_IDLE;
            w_err       = ERR_NONE;
            w_opSel     = '0;
        end else begin
            case (r_state)
                S_IDLE, S_HAVE_A, S_HAVE_B, S_HAVE_AB, S_DONE: begin
                    w_loadA = w_edgeA;
                    w_loadB = w_edgeB;
                    if (w_edgeA || w_edgeB) begin
                        w_nextState = haveState(w_hasA | w_edgeA, w_hasB | w_edgeB);
                    end
                    if ((r_state == S_HAVE_AB) && w_edgeExec) begin
                        if (w_legal) begin
                            w_nextState = S_EXEC;
                            w_opSel     = NUM_OPS'(1) << op;
                            w_start     = 1'b1;
                            w_wd        = '0;
                        end else begin
                            w_nextState = S_ERROR;
                            w_opSel     = '0;
                            w_err       = ERR_ILLEGAL_OP;
                        end
                    end
                end
                S_EXEC: begin
                    // A done arriving on the timeout cycle still counts as done.
                    if (aluDone) begin
                        w_nextState = aluErr ? S_ERROR : S_DONE;
                        w_err       = aluErr ? ERR_ALU : ERR_NONE;
                    end else if (r_wd == c_wdLast) begin
                        w_nextState = S_ERROR;
                        w_err       = ERR_TIMEOUT;
                    end else begin
                        w_wd = r_wd + WD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wd          <= '0;
            r_opSel       <= '0;
            r_err         <= ERR_NONE;
            r_loadA       <= 1'b0;
            r_loadB       <= 1'b0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_resultValid <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_wd          <= w_wd;
            r_opSel       <= w_opSel;
            r_err         <= w_err;
            r_loadA       <= w_loadA;
            r_loadB       <= w_loadB;
            r_start       <= w_start;
            r_busy        <= (w_nextState == S_EXEC);
            r_resultValid <= (w_nextState == S_DONE);
        end
    end

    assign loadA       = r_loadA;
    assign loadB       = r_loadB;
    assign opSel       = r_opSel;
    assign aluStart    = r_start;
    assign busy        = r_busy;
    assign resultValid = r_resultValid;
    assign errCode     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Brief    : Directed bench for calc_sequencer (4-op and 3-op instances).
// Revision : 1.0
// ============================================================================
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       rst, btnLoadA, btnLoadB, btnExec, btnClear, aluDone, aluErr;
    logic [1:0] op;

    logic       loadA0, loadB0, aluStart0, busy0, resultValid0;
    logic [3:0] opSel0;
    logic [1:0] errCode0;
    logic       loadA1, loadB1, aluStart1, busy1, resultValid1;
    logic [2:0] opSel1;
    logic [1:0] errCode1;

    int vecs = 0;
    int errs = 0;
    int n;

    wire [10:0] outs0 = {loadA0, loadB0, aluStart0, busy0, resultValid0, opSel0, errCode0};
    wire [9:0]  outs1 = {loadA1, loadB1, aluStart1, busy1, resultValid1, opSel1, errCode1};

    always #5 clk = ~clk;

    calc_sequencer #(.OP_W(2), .NUM_OPS(4), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst), .btnLoadA(btnLoadA), .btnLoadB(btnLoadB),
        .btnExec(btnExec), .btnClear(btnClear), .op(op), .aluDone(aluDone),
        .aluErr(aluErr), .loadA(loadA0), .loadB(loadB0), .opSel(opSel0),
        .aluStart(aluStart0), .busy(busy0), .resultValid(resultValid0),
        .errCode(errCode0)
    );

    calc_sequencer #(.OP_W(2), .NUM_OPS(3), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .btnLoadA(btnLoadA), .btnLoadB(btnLoadB),
        .btnExec(btnExec), .btnClear(btnClear), .op(op), .aluDone(aluDone),
        .aluErr(aluErr), .loadA(loadA1), .loadB(loadB1), .opSel(opSel1),
        .aluStart(aluStart1), .busy(busy1), .resultValid(resultValid1),
        .errCode(errCode1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; btnLoadA = 1'b0; btnLoadB = 1'b0; btnExec = 1'b0;
        btnClear = 1'b0; aluDone = 1'b0; aluErr = 1'b0; op = 2'd0;
        step(); step();
        chk("reset_outs0", 32'(outs0), 32'h0);
        chk("reset_outs1", 32'(outs1), 32'h0);
        rst = 1'b0;
        step();
        chk("idle_outs0", 32'(outs0), 32'h0);

        // Single held A press: one pulse, one cycle after the rise.
        btnLoadA = 1'b1; step();
        chk("loadA_pulse", 32'(loadA0), 32'd1);
        chk("loadB_quiet", 32'(loadB0), 32'd0);
        n = 0;
        for (int i = 0; i < 9; i++) begin step(); n += int'(loadA0); end
        chk("loadA_held_once", n, 0);
        btnLoadA = 1'b0; step();

        // Exec ignored in HAVE_A.
        btnExec = 1'b1; op = 2'd1; step();
        chk("exec_ign_haveA", 32'({aluStart0, busy0}), 32'h0);
        btnExec = 1'b0; step();
        btnLoadB = 1'b1; step();
        chk("loadB_pulse", 32'(loadB0), 32'd1);
        btnLoadB = 1'b0; step();
        btnExec = 1'b1; step();
        chk("exec_haveAB_start", 32'(aluStart0), 32'd1);
        chk("exec_op1_sel", 32'(opSel0), 32'h2);
        btnExec = 1'b0; btnClear = 1'b1; step();
        chk("clear_exec", 32'({busy0, opSel0, errCode0}), 32'h0);
        btnClear = 1'b0; aluDone = 1'b1; step();
        chk("late_done_ign", 32'(resultValid0), 32'd0);
        aluDone = 1'b0; step();

        // Simultaneous A/B, exec MUL, done after 5 cycles.
        btnLoadA = 1'b1; btnLoadB = 1'b1; step();
        chk("loadAB_together", 32'({loadA0, loadB0}), 32'h3);
        btnLoadA = 1'b0; btnLoadB = 1'b0; op = 2'd2; btnExec = 1'b1; step();
        chk("mul_start", 32'(aluStart0), 32'd1);
        chk("mul_sel", 32'(opSel0), 32'h4);
        chk("mul_busy", 32'(busy0), 32'd1);
        btnExec = 1'b0; step();
        chk("start_one_cycle", 32'({aluStart0, busy0}), 32'h1);
        step(); step(); step();
        aluDone = 1'b1; step();
        chk("done_state", 32'({busy0, resultValid0, errCode0}), 32'h4);
        aluDone = 1'b0; step();
        chk("done_hold", 32'({resultValid0, opSel0}), 32'h14);

        // DONE -> loads -> DIV: ALU error on dut0, illegal op on dut1.
        btnLoadA = 1'b1; btnLoadB = 1'b1; step();
        chk("done_reload", 32'({loadA0, loadB0, resultValid0}), 32'h6);
        btnLoadA = 1'b0; btnLoadB = 1'b0; op = 2'd3; btnExec = 1'b1; step();
        chk("div_start", 32'({aluStart0, opSel0}), 32'h18);
        chk("illegal_op", 32'({aluStart1, busy1, opSel1, errCode1}), 32'h1);
        btnExec = 1'b0; aluDone = 1'b1; aluErr = 1'b1; step();
        chk("alu_err", 32'({busy0, errCode0}), 32'h2);
        chk("illegal_done_ign", 32'(errCode1), 32'h1);
        aluDone = 1'b0; aluErr = 1'b0; btnLoadA = 1'b1; step();
        chk("err_load_ign0", 32'({loadA0, errCode0}), 32'h2);
        chk("err_load_ign1", 32'(loadA1), 32'd0);
        btnLoadA = 1'b0; step();
        btnClear = 1'b1; step();
        chk("err_clear0", 32'({opSel0, errCode0}), 32'h0);
        chk("err_clear1", 32'(errCode1), 32'h0);
        btnClear = 1'b0; step();

        // Watchdog timeout with aluDone withheld.
        btnLoadA = 1'b1; btnLoadB = 1'b1; step();
        btnLoadA = 1'b0; btnLoadB = 1'b0; op = 2'd0; btnExec = 1'b1; step();
        chk("add_start", 32'(aluStart0), 32'd1);
        btnExec = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(); n++;
            if (errCode0 == 2'b11) break;
        end
        chk("timeout_cycles", n, 8);
        chk("timeout_err", 32'({busy0, errCode0}), 32'h3);
        btnClear = 1'b1; step();
        btnClear = 1'b0; step();

        // aluDone on the timeout cycle wins.
        btnLoadA = 1'b1; btnLoadB = 1'b1; step();
        btnLoadA = 1'b0; btnLoadB = 1'b0; btnExec = 1'b1; step();
        btnExec = 1'b0;
        repeat (7) step();
        chk("pre_timeout_busy", 32'({busy0, errCode0}), 32'h4);
        aluDone = 1'b1; step();
        chk("done_on_timeout", 32'({resultValid0, errCode0}), 32'h4);
        aluDone = 1'b0; step();

        // Reset mid-EXEC with A held: no pulse until a fresh rise.
        btnLoadA = 1'b1; btnLoadB = 1'b1; step();
        btnLoadA = 1'b0; btnLoadB = 1'b0; op = 2'd1; btnExec = 1'b1; step();
        btnExec = 1'b0; step();
        chk("exec_busy_pre_rst", 32'(busy0), 32'd1);
        rst = 1'b1; btnLoadA = 1'b1; step();
        chk("rst_mid_exec0", 32'(outs0), 32'h0);
        chk("rst_mid_exec1", 32'(outs1), 32'h0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin step(); n += int'(loadA0); end
        chk("held_through_rst", n, 0);
        btnLoadA = 1'b0; step();
        btnLoadA = 1'b1; step();
        chk("fresh_rise_after_rst", 32'(loadA0), 32'd1);
        btnLoadA = 1'b0; step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
